// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers core-side stores and issues one byte
// at a time over a wr_data/wr_en strobe interface, paced by the transmitter busy flag.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [7:0]        tx_data,
    output logic              tx_wr_en,
    input  logic              tx_busy,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              push, pop;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_FULL);
    assign in_ready   = !fifo_full;

    // Readiness comes from registered full only, so a same-cycle pop never frees a slot.
    assign push = in_valid && !fifo_full && !flush;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !tx_busy && !flush) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)  state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_wr_en <= 1'b0;
        end else begin
            state    <= state_next;
            tx_wr_en <= pop;
            if (pop) tx_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (in_valid && fifo_full) overflow <= 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for cycle-level behaviour plus
// hand-written sequences driven through a simple 11-cycle transmitter model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] tx_data;
    logic       tx_wr_en;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;

    logic       force_busy;
    logic       model_on;
    logic [3:0] tx_cnt;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] got[$];
    int         viol;
    int         max_cnt;
    logic       prev_wr, prev_busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .tx_data(tx_data), .tx_wr_en(tx_wr_en),
        .tx_busy(tx_busy), .fifo_count(fifo_count), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    // Transmitter model: busy rises the cycle after wr_en is sampled, for 11 bit times.
    assign tx_busy = force_busy || (tx_cnt != 4'd0);
    always @(posedge clk) begin
        if (!model_on)          tx_cnt <= 4'd0;
        else if (tx_cnt != 4'd0) tx_cnt <= tx_cnt - 4'd1;
        else if (tx_wr_en)      tx_cnt <= 4'd11;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            prev_wr   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (tx_wr_en) begin
                got.push_back(tx_data);
                if (prev_wr || prev_busy) viol++;
            end
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            prev_wr   = tx_wr_en;
            prev_busy = tx_busy;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; model_on = 1'b0; force_busy = 1'b0;
        in_valid = 1'b0; flush = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        viol = 0;
        max_cnt = 0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        in_data = d;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("wait_bytes", 32'(got.size() >= n), 32'd1);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       fl;
        logic       busy;
        int         cnt;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       wr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{8'h11, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{8'h22, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{8'h33, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{8'h44, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{8'h55, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44};
        vecs[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        vecs[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        vecs[10] = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
        vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[13] = '{8'h66, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[16] = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66};
        vecs[17] = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66};

        // Reset values
        do_reset();
        #1;
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_wr", 32'(tx_wr_en), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);

        // Vector table, transmitter busy driven directly
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            in_data = vecs[i].d; in_valid = vecs[i].v;
            flush = vecs[i].fl; force_busy = vecs[i].busy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_empty", i), 32'(fifo_empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d_full", i), 32'(fifo_full), 32'(vecs[i].full));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_wr", i), 32'(tx_wr_en), 32'(vecs[i].wr));
            chk($sformatf("v%0d_data", i), 32'(tx_data), 32'(vecs[i].data));
        end
        idle_in();
        flush = 1'b0;
        chk("tbl_viol", 32'(viol), 32'd0);

        // Three consecutive bytes, exact first-byte latency
        do_reset();
        model_on = 1'b1;
        push_byte(8'h41);
        #1 chk("a_lat_wr0", 32'(tx_wr_en), 32'd0);
        push_byte(8'h42);
        #1 chk("a_lat_wr1", 32'(tx_wr_en), 32'd1);
        chk("a_lat_data", 32'(tx_data), 32'h41);
        push_byte(8'h43);
        idle_in();
        wait_got(3, 200);
        repeat (20) @(posedge clk);
        #1;
        chk("a_nbytes", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk($sformatf("a_byte%0d", i), 32'(got[i]), 32'h41 + 32'(i));
        chk("a_peak_ok", 32'(max_cnt == 2 || max_cnt == 3), 32'd1);
        chk("a_count_end", 32'(fifo_count), 32'd0);
        chk("a_viol", 32'(viol), 32'd0);

        // Fill to full under busy, overflow, then drain
        do_reset();
        force_busy = 1'b1;
        model_on = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        #1;
        chk("b_count16", 32'(fifo_count), 32'd16);
        chk("b_full", 32'(fifo_full), 32'd1);
        chk("b_ready", 32'(in_ready), 32'd0);
        chk("b_ovf_pre", 32'(overflow), 32'd0);
        push_byte(8'hFF);
        #1;
        chk("b_ovf", 32'(overflow), 32'd1);
        chk("b_count_hold", 32'(fifo_count), 32'd16);
        idle_in();
        force_busy = 1'b0;
        wait_got(16, 400);
        repeat (30) @(posedge clk);
        #1;
        chk("b_nbytes", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk($sformatf("b_byte%0d", i), 32'(got[i]), 32'(i));
        chk("b_viol", 32'(viol), 32'd0);

        // Pointer wrap: 10 bytes, drain, 10 more
        do_reset();
        model_on = 1'b1;
        for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i));
        idle_in();
        wait_got(10, 300);
        repeat (20) @(posedge clk);
        for (int i = 0; i < 10; i++) push_byte(8'h20 + 8'(i));
        idle_in();
        wait_got(20, 300);
        repeat (20) @(posedge clk);
        #1;
        chk("c_nbytes", 32'(got.size()), 32'd20);
        for (int i = 0; i < 20 && i < got.size(); i++)
            chk($sformatf("c_byte%0d", i), 32'(got[i]),
                (i < 10) ? 32'h10 + 32'(i) : 32'h20 + 32'(i - 10));
        chk("c_empty", 32'(fifo_empty), 32'd1);

        // Flush during WAIT_DONE with a same-cycle push
        do_reset();
        model_on = 1'b1;
        push_byte(8'h55);
        for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
        idle_in();
        #1;
        chk("d_count5", 32'(fifo_count), 32'd5);
        chk("d_busy", 32'(tx_busy), 32'd1);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        @(posedge clk);
        #1;
        chk("d_count0", 32'(fifo_count), 32'd0);
        chk("d_ovf", 32'(overflow), 32'd0);
        chk("d_empty", 32'(fifo_empty), 32'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("d_nbytes", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("d_byte", 32'(got[0]), 32'h55);

        // Async reset mid-WAIT_DONE
        do_reset();
        model_on = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i));
        idle_in();
        #1;
        chk("e_count4", 32'(fifo_count), 32'd4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("e_wr", 32'(tx_wr_en), 32'd0);
        chk("e_count", 32'(fifo_count), 32'd0);
        chk("e_empty", 32'(fifo_empty), 32'd1);
        chk("e_state", 32'(dut.state), 32'd0);
        do_reset();
        model_on = 1'b1;
        push_byte(8'h7E);
        idle_in();
        wait_got(1, 100);
        if (got.size() > 0) chk("e_byte", 32'(got[0]), 32'h7E);

        // Busy held 50 cycles with one byte queued
        do_reset();
        force_busy = 1'b1;
        push_byte(8'h99);
        idle_in();
        begin
            int bad = 0;
            for (int i = 0; i < 50; i++) begin
                @(posedge clk);
                #1;
                if (tx_wr_en) bad++;
            end
            chk("f_no_wr", 32'(bad), 32'd0);
        end
        @(negedge clk);
        force_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("f_wr", 32'(tx_wr_en), 32'd1);
        chk("f_data", 32'(tx_data), 32'h99);
        @(posedge clk);
        #1;
        chk("f_wr_once", 32'(tx_wr_en), 32'd0);
        chk("f_viol", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
